// File: rtl/taxi_pcie_msi_pkg.sv
// rtl/taxi_pcie_msi_pkg.sv - shared types and constants for the MSI generator
package taxi_pcie_msi_pkg;

    localparam int MSI_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } msi_state_t;

    // Both operands are a power of two minus one, so the AND is the smaller of the two.
    function automatic logic [MSI_MAX-1:0] vec_fold_mask(input logic [2:0] mmenable, input int msi_cnt);
        logic [MSI_MAX-1:0] mm_m1;
        mm_m1 = (MSI_MAX'(1) << mmenable) - MSI_MAX'(1);
        return mm_m1 & MSI_MAX'(msi_cnt - 1);
    endfunction

endpackage

// File: rtl/taxi_pcie_msi_rr_arb.sv
// rtl/taxi_pcie_msi_rr_arb.sv - combinational round-robin find-first-set from last_grant+1
module taxi_pcie_msi_rr_arb #(
    parameter int N     = 32,
    parameter int IDX_W = 5
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= N; i++) begin
            cand = (last_grant + IDX_W'(i)) & IDX_W'(N - 1);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/taxi_pcie_us_msi.sv
// rtl/taxi_pcie_us_msi.sv - MSI pending/mask tracking and cfg_interrupt_msi issue handshake
module taxi_pcie_us_msi
    import taxi_pcie_msi_pkg::*;
#(
    parameter int MSI_CNT = 32,
    parameter int TIMEOUT = 255,
    parameter int VEC_W   = (MSI_CNT > 1) ? $clog2(MSI_CNT) : 1
) (
    input  logic             pcie_clk,
    input  logic             pcie_rst,

    input  logic [VEC_W-1:0] irq_vec,
    input  logic             irq_valid,

    input  logic [3:0]       cfg_interrupt_msi_enable,
    input  logic [11:0]      cfg_interrupt_msi_mmenable,
    input  logic             cfg_interrupt_msi_mask_update,
    input  logic [31:0]      cfg_interrupt_msi_data,
    input  logic             cfg_interrupt_msi_sent,
    input  logic             cfg_interrupt_msi_fail,
    output logic [1:0]       cfg_interrupt_msi_select,
    output logic [31:0]      cfg_interrupt_msi_int,
    output logic [31:0]      cfg_interrupt_msi_pending_status,
    output logic             cfg_interrupt_msi_pending_status_data_enable,
    output logic [1:0]       cfg_interrupt_msi_pending_status_function_num,
    output logic [2:0]       cfg_interrupt_msi_attr,
    output logic             cfg_interrupt_msi_tph_present,
    output logic [1:0]       cfg_interrupt_msi_tph_type,
    output logic [7:0]       cfg_interrupt_msi_tph_st_tag,
    output logic [7:0]       cfg_interrupt_msi_function_number
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    msi_state_t         state_q, state_d;
    logic [MSI_CNT-1:0] pending_q, pending_d;
    logic [MSI_CNT-1:0] mask_q, mask_d;
    logic [MSI_CNT-1:0] eligible;
    logic               mask_upd_q, mask_upd_d;
    logic               pend_chg_q, pend_chg_d;
    logic               rearm_q, rearm_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [VEC_W-1:0]   last_grant_q, last_grant_d;
    logic [VEC_W-1:0]   req_idx, grant_idx;
    logic               grant_valid;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [MSI_MAX-1:0] fold_mask;
    logic               sent_ok;
    logic               unused_cfg;

    assign fold_mask  = vec_fold_mask(cfg_interrupt_msi_mmenable[2:0], MSI_CNT);
    assign req_idx    = irq_vec & fold_mask[VEC_W-1:0];
    assign eligible   = pending_q & ~mask_q;
    // A simultaneous fail overrides sent, so the vector stays pending for a retry.
    assign sent_ok    = (state_q == ST_WAIT) && cfg_interrupt_msi_sent && !cfg_interrupt_msi_fail;
    assign unused_cfg = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3],
                          fold_mask[MSI_MAX-1:VEC_W]};

    taxi_pcie_msi_rr_arb #(
        .N     (MSI_CNT),
        .IDX_W (VEC_W)
    ) u_arb (
        .req         (eligible),
        .last_grant  (last_grant_q),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (cfg_interrupt_msi_enable[0] && grant_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (cfg_interrupt_msi_fail || cfg_interrupt_msi_sent ||
                          tmo_q == TMO_W'(TIMEOUT)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vec_d        = vec_q;
        last_grant_d = last_grant_q;
        tmo_d        = tmo_q;
        rearm_d      = 1'b0;
        if (state_q == ST_IDLE && state_d == ST_ISSUE) begin
            vec_d        = grant_idx;
            last_grant_d = grant_idx;
        end
        if (state_q == ST_ISSUE) begin
            tmo_d = '0;
        end else if (state_q == ST_WAIT) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        // A request for the in-flight vector seen during WAIT must survive the sent clear.
        if (state_q == ST_WAIT) begin
            rearm_d = rearm_q | (irq_valid && req_idx == vec_q);
        end

        pending_d = pending_q;
        if (sent_ok && !rearm_q) begin
            pending_d[vec_q] = 1'b0;
        end
        if (irq_valid) begin
            pending_d[req_idx] = 1'b1;
        end
        pend_chg_d = (pending_d != pending_q);

        mask_upd_d = cfg_interrupt_msi_mask_update;
        mask_d     = mask_upd_q ? cfg_interrupt_msi_data[MSI_CNT-1:0] : mask_q;
    end

    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            pending_q    <= '0;
            mask_q       <= '0;
            mask_upd_q   <= 1'b0;
            pend_chg_q   <= 1'b0;
            rearm_q      <= 1'b0;
            vec_q        <= '0;
            last_grant_q <= VEC_W'(MSI_CNT - 1);
            tmo_q        <= '0;
        end else begin
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            mask_upd_q   <= mask_upd_d;
            pend_chg_q   <= pend_chg_d;
            rearm_q      <= rearm_d;
            vec_q        <= vec_d;
            last_grant_q <= last_grant_d;
            tmo_q        <= tmo_d;
        end
    end

    always_comb begin
        cfg_interrupt_msi_int = '0;
        if (state_q == ST_ISSUE) begin
            cfg_interrupt_msi_int = 32'd1 << vec_q;
        end
    end

    assign cfg_interrupt_msi_pending_status              = 32'(pending_q);
    assign cfg_interrupt_msi_pending_status_data_enable  = pend_chg_q;
    assign cfg_interrupt_msi_select                      = 2'd0;
    assign cfg_interrupt_msi_pending_status_function_num = 2'd0;
    assign cfg_interrupt_msi_attr                        = 3'd0;
    assign cfg_interrupt_msi_tph_present                 = 1'b0;
    assign cfg_interrupt_msi_tph_type                    = 2'd0;
    assign cfg_interrupt_msi_tph_st_tag                  = 8'd0;
    assign cfg_interrupt_msi_function_number             = 8'd0;

endmodule
